// File: rtl/adder_bist_pkg.sv
// Shared types and LFSR helpers for the adder BIST block.
package adder_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } bist_state_e;

  localparam logic [31:0] BIST_POLY         = 32'h8020_0003;
  localparam logic [31:0] BIST_DEFAULT_SEED = 32'h0000_0123;

  // Right-shifting Galois step for x^32+x^22+x^2+x+1.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? BIST_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/adder_bist_if.sv
// Operand/result bundle between the BIST block (master) and the adder under test (slave).
interface adder_bist_if #(
  parameter int WIDTH = 4
) ();

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             c_out;
  logic [WIDTH-1:0] sum;

  modport master (output a, b, c_in, input c_out, sum);
  modport slave  (input a, b, c_in, output c_out, sum);

endinterface

// File: rtl/adder_bist_lfsr.sv
// 32-bit Galois register with load, step and a data-XOR input (zero for plain LFSR, response for MISR).
module adder_bist_lfsr
  import adder_bist_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [31:0] load_val_i,
  input  logic [31:0] data_i,
  output logic [31:0] value_o
);

  logic [31:0] value_q;
  logic [31:0] value_d;

  always_comb begin
    value_d = value_q;
    if (load_i) begin
      value_d = load_val_i;
    end else if (step_i) begin
      value_d = lfsr_next(value_q) ^ data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/adder_bist.sv
// Built-in pseudo-random stimulus/response checker for the combinational adder.
// Define ADDER_BIST_SIGNATURE_EN to add the MISR and the signature port.
module adder_bist
  import adder_bist_pkg::*;
#(
  parameter int          WIDTH       = 4,
  parameter int          NUM_VECTORS = 16,
  parameter logic [31:0] SEED        = BIST_DEFAULT_SEED
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  adder_bist_if.master adr,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [15:0]  err_count,
  output logic [15:0]  fail_idx,
`ifdef ADDER_BIST_SIGNATURE_EN
  output logic [31:0]  signature,
`endif
  output bist_state_e  state_o
);

  // start is a level request honoured only in IDLE; done is a one-cycle completion pulse.
  localparam int             OPW      = 2 * WIDTH + 1;
  localparam logic [31:0]    SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [OPW-1:0] OP_SEED  = OPW'(SEED_EFF);
  localparam logic [15:0]    LAST_IDX = 16'(NUM_VECTORS - 1);

  bist_state_e      state_q;
  logic [15:0]      idx_q, err_q, fail_q, err_d;
  logic             pass_q, done_q, busy_q, c_in_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH:0]   expected, observed;
  logic [OPW-1:0]   op_nxt;
  logic [31:0]      lfsr_val;
  logic             mismatch, run_start, sample_en;

  assign run_start = (state_q == ST_IDLE) && start;
  assign sample_en = (state_q == ST_SAMPLE);
  assign expected  = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, c_in_q};
  assign observed  = {adr.c_out, adr.sum};
  assign mismatch  = (expected != observed);
  assign op_nxt    = OPW'(lfsr_next(lfsr_val));

  always_comb begin
    err_d = err_q;
    if (sample_en && mismatch && (err_q != 16'hFFFF)) begin
      err_d = err_q + 16'd1;
    end
  end

  adder_bist_lfsr u_lfsr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (run_start),
    .step_i     (sample_en),
    .load_val_i (SEED_EFF),
    .data_i     (32'h0),
    .value_o    (lfsr_val)
  );

`ifdef ADDER_BIST_SIGNATURE_EN
  adder_bist_lfsr u_misr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (run_start),
    .step_i     (sample_en),
    .load_val_i (32'h0),
    .data_i     (32'(observed)),
    .value_o    (signature)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= ST_IDLE;
      idx_q             <= '0;
      err_q             <= '0;
      fail_q            <= '0;
      pass_q            <= 1'b0;
      done_q            <= 1'b0;
      busy_q            <= 1'b0;
      {c_in_q, b_q, a_q} <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            idx_q             <= '0;
            err_q             <= '0;
            fail_q            <= '0;
            pass_q            <= 1'b0;
            busy_q            <= 1'b1;
            {c_in_q, b_q, a_q} <= OP_SEED;
            state_q           <= ST_DRIVE;
          end
        end
        ST_DRIVE: state_q <= ST_SAMPLE;
        ST_SAMPLE: begin
          err_q <= err_d;
          if (mismatch && (err_q == 16'd0)) begin
            fail_q <= idx_q;
          end
          idx_q <= idx_q + 16'd1;
          // pass and done are registered on the way into DONE so they are valid during it.
          if (idx_q == LAST_IDX) begin
            state_q           <= ST_DONE;
            busy_q            <= 1'b0;
            done_q            <= 1'b1;
            pass_q            <= (err_d == 16'd0);
            {c_in_q, b_q, a_q} <= '0;
          end else begin
            state_q           <= ST_DRIVE;
            {c_in_q, b_q, a_q} <= op_nxt;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign adr.a     = a_q;
  assign adr.b     = b_q;
  assign adr.c_in  = c_in_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_idx  = fail_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_adder_bist.sv
// Bench for adder_bist: vector table, randomized fault runs against a spec-level model, reset and seed corner cases.
`timescale 1ns/1ps
module tb_adder_bist;
  import adder_bist_pkg::*;

  localparam int W   = 4;
  localparam int NV  = 5;
  localparam int OPW = 2 * W + 1;

  logic clk = 1'b0;
  logic rst_n, start, start0;
  logic fault_zero, fault_inv, fault_flip;
  logic busy, done, pass, busy0, done0, pass0;
  logic [15:0] err_count, fail_idx, err0, fidx0;
  bist_state_e state, state0;
`ifdef ADDER_BIST_SIGNATURE_EN
  logic [31:0] signature, signature0;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [OPW-1:0] exp_q[$];
  logic [OPW-1:0] ops[NV];

  typedef struct {
    logic [NV-1:0] zm;
    logic [NV-1:0] im;
    logic [NV-1:0] fm;
    int            pulse;
    logic [15:0]   err;
    logic [15:0]   fidx;
    logic          pass;
  } vec_t;
  vec_t tbl[5];

  // ---------------- clock / DUTs ----------------
  always #5 clk = ~clk;

  adder_bist_if #(.WIDTH(W)) adr  ();
  adder_bist_if #(.WIDTH(W)) adr0 ();

  adder_bist #(.WIDTH(W), .NUM_VECTORS(NV)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .adr(adr),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_idx(fail_idx),
`ifdef ADDER_BIST_SIGNATURE_EN
    .signature(signature),
`endif
    .state_o(state)
  );

  adder_bist #(.WIDTH(W), .NUM_VECTORS(NV), .SEED(32'h0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .adr(adr0),
    .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .fail_idx(fidx0),
`ifdef ADDER_BIST_SIGNATURE_EN
    .signature(signature0),
`endif
    .state_o(state0)
  );

  // Adder under test, with injectable faults on the first DUT.
  always_comb begin
    {adr.c_out, adr.sum} = {1'b0, adr.a} + {1'b0, adr.b} + {{W{1'b0}}, adr.c_in};
    if (fault_zero) adr.sum = '0;
    if (fault_flip) adr.sum[0] = ~adr.sum[0];
    if (fault_inv)  adr.c_out = ~adr.c_out;
  end
  assign {adr0.c_out, adr0.sum} = {1'b0, adr0.a} + {1'b0, adr0.b} + {{W{1'b0}}, adr0.c_in};

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_step(input logic [31:0] s);
    logic [31:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 32'h8020_0003;
    return r;
  endfunction

  task automatic model_run(input logic [NV-1:0] zm, input logic [NV-1:0] im,
                           input logic [NV-1:0] fm,
                           output logic [15:0] err, output logic [15:0] fidx);
    int a, b, c, tru, obs;
    err  = 16'd0;
    fidx = 16'd0;
    for (int k = 0; k < NV; k++) begin
      a   = int'(ops[k][W-1:0]);
      b   = int'(ops[k][2*W-1:W]);
      c   = int'(ops[k][2*W]);
      tru = a + b + c;
      obs = tru;
      if (zm[k]) obs = obs - (obs % (1 << W));
      if (fm[k]) obs = obs ^ 1;
      if (im[k]) obs = obs ^ (1 << W);
      if (obs != tru) begin
        if (err == 16'd0) fidx = 16'(k);
        err = err + 16'd1;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- driver ----------------
  task automatic run(input logic [NV-1:0] zm, input logic [NV-1:0] im,
                     input logic [NV-1:0] fm, input int pulse_cyc,
                     output int done_cyc, output logic [OPW-1:0] first_op,
                     output logic got_pass, output logic [15:0] got_err,
                     output logic [15:0] got_fidx);
    logic [OPW-1:0] cur;
    int k;
    done_cyc = -1;
    first_op = '0;
    got_pass = 1'b0;
    got_err  = '0;
    got_fidx = '0;
    cur      = '0;
    exp_q.delete();
    for (int i = 0; i < NV; i++) exp_q.push_back(ops[i]);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    for (int n = 1; n <= 2 * NV + 3; n++) begin
      k = (n - 1) / 2;
      fault_zero = 1'b0;
      fault_inv  = 1'b0;
      fault_flip = 1'b0;
      if ((n % 2 == 0) && (n <= 2 * NV)) begin
        fault_zero = zm[k];
        fault_inv  = im[k];
        fault_flip = fm[k];
      end
      start = (n == pulse_cyc);
      if ((n <= 2 * NV) && (n % 2 == 1)) begin
        cur = exp_q.pop_front();
        if (n == 1) first_op = {adr.c_in, adr.b, adr.a};
      end
      if (n > 2 * NV) cur = '0;
      check("operands", 32'({adr.c_in, adr.b, adr.a}), 32'(cur));
      check("busy", 32'(busy), 32'(n <= 2 * NV));
      check("done", 32'(done), 32'(n == 2 * NV + 1));
      if (done && (done_cyc < 0)) done_cyc = n;
      if (n == 2 * NV + 1) begin
        got_pass = pass;
        got_err  = err_count;
        got_fidx = fail_idx;
      end
      @(posedge clk);
      #1;
    end
    start      = 1'b0;
    fault_zero = 1'b0;
    fault_inv  = 1'b0;
    fault_flip = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // ---------------- test sequence ----------------
  initial begin
    int dc;
    logic [OPW-1:0] fo;
    logic gp;
    logic [15:0] ge, gf, me, mf;
    logic [NV-1:0] zm, im, fm;
    logic [31:0] s;
`ifdef ADDER_BIST_SIGNATURE_EN
    logic [31:0] sa;
`endif

    rst_n = 1'b0; start = 1'b0; start0 = 1'b0;
    fault_zero = 1'b0; fault_inv = 1'b0; fault_flip = 1'b0;

    s = 32'h0000_0123;
    for (int k = 0; k < NV; k++) begin
      ops[k] = s[OPW-1:0];
      s = model_step(s);
    end

    tbl[0] = '{zm: 5'b00000, im: 5'b00000, fm: 5'b00000, pulse: 0, err: 16'd0, fidx: 16'd0, pass: 1'b1};
    tbl[1] = '{zm: 5'b00001, im: 5'b00000, fm: 5'b00000, pulse: 0, err: 16'd1, fidx: 16'd0, pass: 1'b0};
    tbl[2] = '{zm: 5'b00000, im: 5'b10100, fm: 5'b00000, pulse: 0, err: 16'd2, fidx: 16'd2, pass: 1'b0};
    tbl[3] = '{zm: 5'b00000, im: 5'b00000, fm: 5'b00000, pulse: 4, err: 16'd0, fidx: 16'd0, pass: 1'b1};
    tbl[4] = '{zm: 5'b00000, im: 5'b00000, fm: 5'b01000, pulse: 0, err: 16'd1, fidx: 16'd3, pass: 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check("reset_operands", 32'({adr.c_in, adr.b, adr.a}), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_pass", 32'(pass), 32'h0);
    check("reset_err_count", 32'(err_count), 32'h0);
    check("reset_fail_idx", 32'(fail_idx), 32'h0);
    check("reset_state", 32'(state), 32'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run(tbl[i].zm, tbl[i].im, tbl[i].fm, tbl[i].pulse, dc, fo, gp, ge, gf);
      check("done_cycle", 32'(dc), 32'(2 * NV + 1));
      check("first_vector", 32'(fo), 32'h123);
      check("err_count", 32'(ge), 32'(tbl[i].err));
      check("fail_idx", 32'(gf), 32'(tbl[i].fidx));
      check("pass", 32'(gp), 32'(tbl[i].pass));
    end

    for (int r = 0; r < 8; r++) begin
      zm = NV'($urandom_range(0, 31));
      im = NV'($urandom_range(0, 31));
      fm = NV'($urandom_range(0, 31));
      model_run(zm, im, fm, me, mf);
      run(zm, im, fm, int'($urandom_range(1, 2 * NV + 1)), dc, fo, gp, ge, gf);
      check("rand_done_cycle", 32'(dc), 32'(2 * NV + 1));
      check("rand_err_count", 32'(ge), 32'(me));
      check("rand_fail_idx", 32'(gf), 32'(mf));
      check("rand_pass", 32'(gp), 32'(me == 16'd0));
    end

    // Reset in the middle of a run that already has one error.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    fault_zero = 1'b1;
    @(posedge clk); #1;
    fault_zero = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("err_before_reset", 32'(err_count), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrun_reset_busy", 32'(busy), 32'h0);
    check("midrun_reset_a", 32'(adr.a), 32'h0);
    check("midrun_reset_err_count", 32'(err_count), 32'h0);
    check("midrun_reset_state", 32'(state), 32'(ST_IDLE));
    repeat (3) begin
      @(posedge clk); #1;
      check("midrun_reset_no_done", 32'(done), 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check("after_reset_no_done", 32'(done), 32'h0);
      check("after_reset_idle", 32'(busy), 32'h0);
    end

    // Zero seed is replaced by 1.
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    check("seed0_first_vector", 32'({adr0.c_in, adr0.b, adr0.a}), 32'h001);
    dc = -1;
    for (int n = 1; n <= 2 * NV + 3; n++) begin
      if (done0 && (dc < 0)) begin
        dc = n;
        check("seed0_pass", 32'(pass0), 32'h1);
        check("seed0_err_count", 32'(err0), 32'h0);
      end
      @(posedge clk); #1;
    end
    check("seed0_done_cycle", 32'(dc), 32'(2 * NV + 1));

`ifdef ADDER_BIST_SIGNATURE_EN
    run('0, '0, '0, 0, dc, fo, gp, ge, gf);
    sa = signature;
    check("signature_nonzero", 32'(sa != 32'h0), 32'h1);
    run('0, '0, '0, 0, dc, fo, gp, ge, gf);
    check("signature_repeat", signature, sa);
    run('0, '0, 5'b00100, 0, dc, fo, gp, ge, gf);
    check("signature_flip_differs", 32'(signature !== sa), 32'h1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
